// File: rtl/clk_gate_ctrl.sv
// Clock-gate enable sequencer: wakes CLK_GATE, waits a settle time before granting, and holds the clock through an idle hold-off.
// Optional CLK_GATE_TEST_EN build adds a test_mode input that forces CLK_EN high for scan/DFT.
module clk_gate_ctrl #(
  parameter int NUM_REQ  = 4,
  parameter int WAKE_CYC = 2,
  parameter int IDLE_CYC = 8,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               RST,
  input  logic [NUM_REQ-1:0] req,
`ifdef CLK_GATE_TEST_EN
  input  logic               test_mode,
`endif
  output logic [NUM_REQ-1:0] grant,
  output logic               CLK_EN,
  output logic [1:0]         gate_state
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYC - 1);
  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               clk_en_q, clk_en_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               any_req;
  logic               cnt_done;

  assign any_req  = |req;
  assign cnt_done = (cnt_q == CNT_ZERO);

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_OFF;
      cnt_q    <= CNT_ZERO;
      clk_en_q <= 1'b0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      clk_en_q <= clk_en_d;
      grant_q  <= grant_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clk_en_d = clk_en_q;
    grant_d  = grant_q;
    case (state_q)
      ST_OFF: begin
        clk_en_d = 1'b0;
        grant_d  = '0;
        if (any_req) begin
          state_d  = ST_WAKE;
          clk_en_d = 1'b1;
          cnt_d    = WAKE_LOAD;
        end
      end
      // Settle time always runs to completion so the gate never toggles mid-wake.
      ST_WAKE: begin
        clk_en_d = 1'b1;
        grant_d  = '0;
        if (!cnt_done) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d = ST_ON;
          grant_d = req;
        end
      end
      ST_ON: begin
        clk_en_d = 1'b1;
        if (any_req) begin
          grant_d = req;
        end else begin
          state_d = ST_HOLD;
          grant_d = '0;
          cnt_d   = IDLE_LOAD;
        end
      end
      // A request on the final hold cycle takes priority over shutting off.
      ST_HOLD: begin
        clk_en_d = 1'b1;
        grant_d  = '0;
        if (any_req) begin
          state_d = ST_ON;
          grant_d = req;
        end else if (!cnt_done) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d  = ST_OFF;
          clk_en_d = 1'b0;
        end
      end
      default: begin
        state_d  = ST_OFF;
        clk_en_d = 1'b0;
        grant_d  = '0;
        cnt_d    = CNT_ZERO;
      end
    endcase
  end

  assign grant      = grant_q;
  assign gate_state = state_q;

`ifdef CLK_GATE_TEST_EN
  assign CLK_EN = clk_en_q | test_mode;
`else
  assign CLK_EN = clk_en_q;
`endif

endmodule
